conv_layer_sequencer: RTL and testbench

Layer-level controller for the convolution datapath. It runs one convolution layer from a single `start` pulse. First it loads weight words from DDR into weight memory. Then, for each output-channel group, it selects the group's weights and bias, resets the accumulators and streams the input feature map through the conv unit. Conv results are written back to feature-map memory at sequential addresses. It drives the `current_state`/`state_rst` bus shared by the weight, bias, feature-map and conv blocks, and replaces the external stimulus that currently drives those address and control ports.

---
 rtl/conv_layer_sequencer_if.sv | 54 +++++
 rtl/conv_layer_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Control/address bus between the layer sequencer and the weight, bias,
// feature-map and conv blocks it steers.
interface conv_layer_sequencer_if #(
    parameter int FM_AW  = 13,
    parameter int WM_WAW = 10,
    parameter int WM_RAW = 8,
    parameter int BM_AW  = 9
);
    logic              start;
    logic [WM_WAW-1:0] cfg_wt_words;
    logic [WM_RAW-1:0] cfg_groups;
    logic [FM_AW-1:0]  cfg_pixels;
    logic [8:0]        cfg_line_len;
    logic [3:0]        cfg_scale;
    logic              cfg_pw;
    logic              DDR_valid_in;
    logic              Conv_data_valid_out;

    logic [2:0]        current_state;
    logic              state_rst;
    logic [WM_WAW-1:0] wm_addr_wr;
    logic              wm_cvt_rstn;
    logic [WM_RAW-1:0] wm_addr_rd;
    logic [BM_AW-1:0]  bm_addr_rd;
    logic              bias_out_valid;
    logic              adder_rst;
    logic              buff_len_rst;
    logic [8:0]        buff_len_ctrl;
    logic [3:0]        Conv_scale_in;
    logic              PW_mode;
    logic [FM_AW-1:0]  fm_rd_addr;
    logic              Conv_data_valid_in;
    logic [FM_AW-1:0]  fm_wr_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, cfg_wt_words, cfg_groups, cfg_pixels, cfg_line_len,
               cfg_scale, cfg_pw, DDR_valid_in, Conv_data_valid_out,
        output current_state, state_rst, wm_addr_wr, wm_cvt_rstn, wm_addr_rd,
               bm_addr_rd, bias_out_valid, adder_rst, buff_len_rst,
               buff_len_ctrl, Conv_scale_in, PW_mode, fm_rd_addr,
               Conv_data_valid_in, fm_wr_addr, busy, done
    );

    modport slave (
        output start, cfg_wt_words, cfg_groups, cfg_pixels, cfg_line_len,
               cfg_scale, cfg_pw, DDR_valid_in, Conv_data_valid_out,
        input  current_state, state_rst, wm_addr_wr, wm_cvt_rstn, wm_addr_rd,
               bm_addr_rd, bias_out_valid, adder_rst, buff_len_rst,
               buff_len_ctrl, Conv_scale_in, PW_mode, fm_rd_addr,
               Conv_data_valid_in, fm_wr_addr, busy, done
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Layer controller: loads weights, then per output group fetches bias, clears
// accumulators, streams the feature map and waits for all conv results.
module conv_layer_sequencer #(
    parameter int FM_AW  = 13,
    parameter int WM_WAW = 10,
    parameter int WM_RAW = 8,
    parameter int BM_AW  = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_layer_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD  = 3'd1,
        GSTART = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [WM_WAW-1:0] W_ONE  = {{(WM_WAW-1){1'b0}}, 1'b1};
    localparam logic [WM_RAW-1:0] G_ONE  = {{(WM_RAW-1){1'b0}}, 1'b1};
    localparam logic [FM_AW-1:0]  FM_ONE = {{(FM_AW-1){1'b0}}, 1'b1};
    localparam logic [FM_AW:0]    OC_ONE = {{FM_AW{1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;

    logic [WM_WAW-1:0] wt_words_r;
    logic [WM_RAW-1:0] groups_r;
    logic [FM_AW-1:0]  pixels_r;
    logic [8:0]        line_len_r;
    logic [3:0]        scale_r;
    logic              pw_r;

    logic [WM_WAW-1:0] beat_cnt_r;
    logic [WM_RAW-1:0] group_r;
    logic [FM_AW-1:0]  rd_cnt_r;
    logic [FM_AW-1:0]  wr_ptr_r;
    logic [FM_AW:0]    out_cnt_r;

    logic              state_rst_r;
    logic              wm_cvt_rstn_r;
    logic              bias_valid_r;
    logic              adder_rst_r;
    logic              buff_len_rst_r;
    logic              rd_valid_r;
    logic              busy_r;
    logic              done_r;

    logic              start_ok_s;
    logic              last_beat_s;
    logic              stream_last_s;
    logic              drain_ok_s;
    logic              last_group_s;
    logic              out_hit_s;

    assign start_ok_s    = (state_r == IDLE) && bus.start;
    assign last_beat_s   = (wt_words_r == {WM_WAW{1'b0}}) ||
                           (bus.DDR_valid_in && (beat_cnt_r == wt_words_r - W_ONE));
    assign stream_last_s = (pixels_r == {FM_AW{1'b0}}) || (rd_cnt_r == pixels_r - FM_ONE);
    assign drain_ok_s    = (out_cnt_r >= {1'b0, pixels_r});
    assign last_group_s  = (group_r == groups_r - G_ONE);
    // Results are only meaningful while a group is in flight.
    assign out_hit_s     = bus.Conv_data_valid_out &&
                           ((state_r == GSTART) || (state_r == STREAM) || (state_r == DRAIN));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_next_s = WLOAD;
                else           state_next_s = IDLE;
            end
            WLOAD: begin
                if (last_beat_s) begin
                    if (groups_r == {WM_RAW{1'b0}}) state_next_s = DONE;
                    else                            state_next_s = GSTART;
                end else begin
                    state_next_s = WLOAD;
                end
            end
            GSTART: state_next_s = STREAM;
            STREAM: begin
                if (stream_last_s) state_next_s = DRAIN;
                else               state_next_s = STREAM;
            end
            DRAIN: begin
                if (drain_ok_s) begin
                    if (last_group_s) state_next_s = DONE;
                    else              state_next_s = GSTART;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Config latch, counters and registered control strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_words_r     <= {WM_WAW{1'b0}};
            groups_r       <= {WM_RAW{1'b0}};
            pixels_r       <= {FM_AW{1'b0}};
            line_len_r     <= 9'd0;
            scale_r        <= 4'd0;
            pw_r           <= 1'b0;
            beat_cnt_r     <= {WM_WAW{1'b0}};
            group_r        <= {WM_RAW{1'b0}};
            rd_cnt_r       <= {FM_AW{1'b0}};
            wr_ptr_r       <= {FM_AW{1'b0}};
            out_cnt_r      <= {(FM_AW+1){1'b0}};
            state_rst_r    <= 1'b0;
            wm_cvt_rstn_r  <= 1'b1;
            bias_valid_r   <= 1'b0;
            adder_rst_r    <= 1'b0;
            buff_len_rst_r <= 1'b0;
            rd_valid_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_rst_r    <= (state_next_s != state_r);
            wm_cvt_rstn_r  <= !start_ok_s;
            bias_valid_r   <= (state_next_s == GSTART);
            adder_rst_r    <= (state_next_s == GSTART);
            buff_len_rst_r <= (state_next_s == GSTART);
            rd_valid_r     <= (state_next_s == STREAM) && (pixels_r != {FM_AW{1'b0}});
            busy_r         <= (state_next_s != IDLE);
            done_r         <= (state_next_s == DONE);

            if (start_ok_s) begin
                wt_words_r <= bus.cfg_wt_words;
                groups_r   <= bus.cfg_groups;
                pixels_r   <= bus.cfg_pixels;
                line_len_r <= bus.cfg_line_len;
                scale_r    <= bus.cfg_scale;
                pw_r       <= bus.cfg_pw;
                beat_cnt_r <= {WM_WAW{1'b0}};
                group_r    <= {WM_RAW{1'b0}};
                rd_cnt_r   <= {FM_AW{1'b0}};
                wr_ptr_r   <= {FM_AW{1'b0}};
                out_cnt_r  <= {(FM_AW+1){1'b0}};
            end else begin
                if ((state_r == WLOAD) && bus.DDR_valid_in) beat_cnt_r <= beat_cnt_r + W_ONE;
                if ((state_r == DRAIN) && (state_next_s == GSTART)) group_r <= group_r + G_ONE;

                if (state_next_s == GSTART)  rd_cnt_r <= {FM_AW{1'b0}};
                else if (state_r == STREAM)  rd_cnt_r <= rd_cnt_r + FM_ONE;

                // Write pointer spans the whole layer and wraps naturally.
                if (out_hit_s) wr_ptr_r <= wr_ptr_r + FM_ONE;

                if ((state_next_s == GSTART) && (state_r != GSTART)) out_cnt_r <= {(FM_AW+1){1'b0}};
                else if (out_hit_s)                                  out_cnt_r <= out_cnt_r + OC_ONE;
            end
        end
    end

    assign bus.current_state      = state_r;
    assign bus.state_rst          = state_rst_r;
    assign bus.wm_addr_wr         = beat_cnt_r;
    assign bus.wm_cvt_rstn        = wm_cvt_rstn_r;
    assign bus.wm_addr_rd         = group_r;
    assign bus.bm_addr_rd         = {{(BM_AW-WM_RAW){1'b0}}, group_r};
    assign bus.bias_out_valid     = bias_valid_r;
    assign bus.adder_rst          = adder_rst_r;
    assign bus.buff_len_rst       = buff_len_rst_r;
    assign bus.buff_len_ctrl      = line_len_r;
    assign bus.Conv_scale_in      = scale_r;
    assign bus.PW_mode            = pw_r;
    assign bus.fm_rd_addr         = rd_cnt_r;
    assign bus.Conv_data_valid_in = rd_valid_r;
    assign bus.fm_wr_addr         = wr_ptr_r;
    assign bus.busy               = busy_r;
    assign bus.done               = done_r;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: stimulus pushes expected states
// and addresses into queues, a monitor with a conv-unit model pops and checks.
module tb_conv_layer_sequencer;
    logic clk;
    logic rst;

    conv_layer_sequencer_if bus ();

    conv_layer_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_state_q[$];
    int exp_wm_q[$];
    int exp_rd_q[$];
    int exp_wr_q[$];

    int exp_words, exp_pixels, exp_len, exp_scale, exp_pw, lat;
    int grp_seen, done_cnt;
    int cyc, prev_state, wload_entry, last_ddr_cyc, last_out_cyc;
    bit ring [64];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_missing(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event with no expected entry (t=%0t)", name, $time);
    endtask

    // Monitor + conv-unit model, sampled mid-cycle.
    initial begin : monitor
        int st;
        prev_state = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_state = 0;
                for (int i = 0; i < 64; i++) ring[i] = 1'b0;
                bus.Conv_data_valid_out = 1'b0;
                continue;
            end
            st = int'(bus.current_state);
            if ((st != prev_state) || bus.state_rst) begin
                check("state_rst", bus.state_rst, st != prev_state);
                if (st != prev_state) begin
                    if (exp_state_q.size() == 0) check_missing("state");
                    else check("state", st, exp_state_q.pop_front());
                    if (prev_state == 1) begin
                        if (exp_words == 0) check("wload_len", cyc - wload_entry, 1);
                        else check("exit_after_last_beat", cyc, last_ddr_cyc + 1);
                    end
                    if (prev_state == 4 && exp_pixels != 0)
                        check("drain_exit", cyc, last_out_cyc + 2);
                    if (st == 1) wload_entry = cyc;
                end
            end
            prev_state = st;

            if (((st == 1) && bus.state_rst) || !bus.wm_cvt_rstn)
                check("wm_cvt_rstn", bus.wm_cvt_rstn, !((st == 1) && bus.state_rst));
            if ((st == 2) || bus.bias_out_valid)
                check("bias_out_valid", bus.bias_out_valid, st == 2);
            if (st == 2) begin
                check("adder_rst", bus.adder_rst, 1);
                check("buff_len_rst", bus.buff_len_rst, 1);
                check("wm_addr_rd", bus.wm_addr_rd, grp_seen);
                check("bm_addr_rd", bus.bm_addr_rd, grp_seen);
                check("buff_len_ctrl", bus.buff_len_ctrl, exp_len);
                check("Conv_scale_in", bus.Conv_scale_in, exp_scale);
                check("PW_mode", bus.PW_mode, exp_pw);
                grp_seen++;
            end
            if ((st == 5) || bus.done) begin
                check("done", bus.done, st == 5);
                if (bus.done) done_cnt++;
            end
            if ((st == 0) || (st == 5)) check("busy", bus.busy, st != 0);

            if (bus.DDR_valid_in && st == 1) begin
                if (exp_wm_q.size() == 0) check_missing("wm_addr_wr");
                else check("wm_addr_wr", bus.wm_addr_wr, exp_wm_q.pop_front());
                last_ddr_cyc = cyc;
            end

            if (bus.Conv_data_valid_in) begin
                check("rd_in_stream", st, 3);
                if (exp_rd_q.size() == 0) check_missing("fm_rd_addr");
                else check("fm_rd_addr", bus.fm_rd_addr, exp_rd_q.pop_front());
                ring[(cyc + lat) % 64] = 1'b1;
            end

            bus.Conv_data_valid_out = ring[cyc % 64];
            ring[cyc % 64] = 1'b0;
            if (bus.Conv_data_valid_out && (st >= 2) && (st <= 4)) begin
                if (exp_wr_q.size() == 0) check_missing("fm_wr_addr");
                else check("fm_wr_addr", bus.fm_wr_addr, exp_wr_q.pop_front());
                last_out_cyc = cyc;
            end
        end
    end

    task automatic start_layer(input int words, input int groups, input int pixels,
                               input int len, input int scale, input int pw,
                               input int gapped, input int latency, input bit release_rst);
        int sent;
        int c;
        exp_state_q.push_back(1);
        if (groups == 0) begin
            exp_state_q.push_back(5);
        end else begin
            for (int g = 0; g < groups; g++) begin
                exp_state_q.push_back(2);
                exp_state_q.push_back(3);
                exp_state_q.push_back(4);
            end
            exp_state_q.push_back(5);
        end
        exp_state_q.push_back(0);
        for (int i = 0; i < words; i++) exp_wm_q.push_back(i);
        for (int g = 0; g < groups; g++)
            for (int p = 0; p < pixels; p++) exp_rd_q.push_back(p);
        for (int i = 0; i < groups * pixels; i++) exp_wr_q.push_back(i % 8192);
        exp_words = words; exp_pixels = pixels; exp_len = len;
        exp_scale = scale; exp_pw = pw; lat = latency;
        grp_seen = 0; done_cnt = 0;

        @(negedge clk);
        if (release_rst) rst = 1'b0;
        bus.cfg_wt_words = 10'(words);
        bus.cfg_groups   = 8'(groups);
        bus.cfg_pixels   = 13'(pixels);
        bus.cfg_line_len = 9'(len);
        bus.cfg_scale    = 4'(scale);
        bus.cfg_pw       = 1'(pw);
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sent = 0;
        c = 0;
        while (sent < words) begin
            bus.DDR_valid_in = (gapped != 0) ? (c % 3 == 0) : 1'b1;
            if (bus.DDR_valid_in) sent++;
            c++;
            @(negedge clk);
        end
        bus.DDR_valid_in = 1'b0;
    endtask

    task automatic wait_stream(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.current_state == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_stream_timeout", 0, 1);
    endtask

    task automatic finish_layer();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt > 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        #2;
        check("done_count", done_cnt, 1);
        check("busy_end", bus.busy, 0);
        check("state_q_left", exp_state_q.size(), 0);
        check("wm_q_left", exp_wm_q.size(), 0);
        check("rd_q_left", exp_rd_q.size(), 0);
        check("wr_q_left", exp_wr_q.size(), 0);
    endtask

    task automatic run_layer(input int words, input int groups, input int pixels,
                             input int len, input int scale, input int pw,
                             input int gapped, input int latency, input bit glitch,
                             input bit release_rst);
        bit ok;
        start_layer(words, groups, pixels, len, scale, pw, gapped, latency, release_rst);
        if (glitch) begin
            bus.cfg_wt_words = 10'd7;
            bus.cfg_groups   = 8'd9;
            bus.cfg_pixels   = 13'd11;
            bus.cfg_line_len = 9'd300;
            bus.cfg_scale    = 4'd15;
            bus.cfg_pw       = ~bus.cfg_pw;
            wait_stream(ok);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        finish_layer();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, bus.current_state, 0);
        check({tag, "_state_rst"}, bus.state_rst, 0);
        check({tag, "_wm_cvt_rstn"}, bus.wm_cvt_rstn, 1);
        check({tag, "_busy_done"}, {bus.busy, bus.done}, 0);
        check({tag, "_strobes"}, {bus.bias_out_valid, bus.adder_rst, bus.buff_len_rst,
                                  bus.Conv_data_valid_in}, 0);
        check({tag, "_addrs"}, {bus.wm_addr_wr, bus.wm_addr_rd, bus.fm_rd_addr, bus.fm_wr_addr}, 0);
        check({tag, "_cfg_out"}, {bus.buff_len_ctrl, bus.Conv_scale_in, bus.PW_mode}, 0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.DDR_valid_in = 1'b0;
        bus.Conv_data_valid_out = 1'b0;
        bus.cfg_wt_words = 10'd0;
        bus.cfg_groups = 8'd0;
        bus.cfg_pixels = 13'd0;
        bus.cfg_line_len = 9'd0;
        bus.cfg_scale = 4'd0;
        bus.cfg_pw = 1'b0;
        lat = 1;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // basic layer
        run_layer(4, 2, 3, 37, 5, 0, 0, 4, 1'b0, 1'b0);
        // gapped weight load
        run_layer(4, 1, 2, 100, 3, 1, 1, 3, 1'b0, 1'b0);
        // zero-size configurations
        run_layer(2, 0, 5, 9, 2, 0, 0, 2, 1'b0, 1'b0);
        run_layer(0, 1, 2, 12, 1, 1, 0, 2, 1'b0, 1'b0);
        run_layer(1, 2, 0, 14, 6, 0, 0, 2, 1'b0, 1'b0);
        // slow conv outputs
        run_layer(1, 2, 3, 64, 8, 1, 0, 20, 1'b0, 1'b0);
        // write pointer wraps past 8191
        run_layer(1, 2, 4097, 255, 4, 0, 0, 1, 1'b0, 1'b0);
        // start while busy and config change mid-run
        run_layer(3, 2, 4, 200, 9, 1, 0, 2, 1'b1, 1'b0);

        // reset in the middle of STREAM
        start_layer(1, 1, 8, 50, 7, 1, 0, 2, 1'b0);
        wait_stream(ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_state_q.delete();
        exp_wm_q.delete();
        exp_rd_q.delete();
        exp_wr_q.delete();
        repeat (2) @(negedge clk);
        #2;
        check("midrst_no_done", done_cnt, 0);
        check_reset_outputs("midrst_hold");
        // start together with reset release
        run_layer(2, 1, 3, 21, 2, 0, 0, 3, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
